// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: four-entry register file that issues one instruction at a
// time to an external combinational ALU and writes the ALU result back.
//
// Instruction handshake: an instruction transfers on a rising edge where both
// instr_valid and instr_ready are high. The upstream holds instr_valid and instr
// stable until that edge. instr is ignored whenever instr_ready is low.
// instr_ready is high only while the block is idle and reset is not asserted.
module alu_issue_regfile #(
   parameter int WIDTH = 16,
   parameter int NREG  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   input  logic [7:0]       instr,
   output logic             instr_ready,
   input  logic             ld_en,
   input  logic [1:0]       ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   output logic [1:0]       alu_op,
   output logic [WIDTH-1:0] alu_i0,
   output logic [WIDTH-1:0] alu_i1,
   input  logic [WIDTH-1:0] alu_o,
   input  logic             alu_cout,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             done,
   input  logic [1:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   // Named so checkers can bind to the FSM state hierarchically.
   state_t           state;
   logic [1:0]       rd_q;
   logic [WIDTH-1:0] regs [NREG];
   logic             accept;

   // Ready / accept decode and the combinational debug read port.
   always_comb begin
      instr_ready = (state == IDLE) & ~reset;
      accept      = instr_valid & instr_ready;
      dbg_data    = regs[dbg_addr];
   end

   // FSM, operand capture, write-back and register file. The load is written
   // first so that a write-back to the same register on the same edge wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rd_q   <= 2'd0;
         alu_op <= 2'd0;
         alu_i0 <= '0;
         alu_i1 <= '0;
         result <= '0;
         carry  <= 1'b0;
         done   <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (ld_en) begin
            regs[ld_addr] <= ld_data;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  // Operands read pre-edge contents, so a same-edge load is not seen.
                  state  <= EXEC;
                  rd_q   <= instr[5:4];
                  alu_op <= instr[7:6];
                  alu_i0 <= regs[instr[3:2]];
                  alu_i1 <= regs[instr[1:0]];
               end
            end
            EXEC: begin
               state      <= WB;
               regs[rd_q] <= alu_o;
               result     <= alu_o;
               carry      <= alu_cout;
               done       <= 1'b1;
            end
            WB: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_regfile.sv
// Directed bench for alu_issue_regfile: the bench plays the ALU by driving
// alu_o/alu_cout by hand during EXEC, and checks against hand-computed values.
module tb_alu_issue_regfile;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             instr_valid;
   logic [7:0]       instr;
   logic             instr_ready;
   logic             ld_en;
   logic [1:0]       ld_addr;
   logic [WIDTH-1:0] ld_data;
   logic [1:0]       alu_op;
   logic [WIDTH-1:0] alu_i0;
   logic [WIDTH-1:0] alu_i1;
   logic [WIDTH-1:0] alu_o;
   logic             alu_cout;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             done;
   logic [1:0]       dbg_addr;
   logic [WIDTH-1:0] dbg_data;

   int vectors    = 0;
   int miscompares = 0;

   alu_issue_regfile #(.WIDTH(WIDTH), .NREG(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_ready(instr_ready),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .alu_op     (alu_op),
      .alu_i0     (alu_i0),
      .alu_i1     (alu_i1),
      .alu_o      (alu_o),
      .alu_cout   (alu_cout),
      .result     (result),
      .carry      (carry),
      .done       (done),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   // Clock: 10 ns period, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Advance to 1 ns after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                        input logic [WIDTH-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input logic [1:0] idx,
                            input logic [WIDTH-1:0] exp);
      dbg_addr = idx;
      #1;
      check(tag, dbg_data, exp);
   endtask

   // Issue one instruction at the current (ready) cycle and play the ALU with
   // o/cout during EXEC. Any load the caller set up lands on the accept edge.
   // Checks the ready/done timing: ready low 2 cycles, done high 1 cycle.
   task automatic issue(input string tag, input logic [7:0] ins,
                        input logic [WIDTH-1:0] o, input logic cout);
      check({tag, "_ready_pre"}, {15'd0, instr_ready}, 16'd1);
      instr_valid = 1'b1;
      instr       = ins;
      tick();                           // accept edge E0
      instr_valid = 1'b0;
      ld_en       = 1'b0;
      alu_o       = o;
      alu_cout    = cout;
      check({tag, "_ready_exec"}, {15'd0, instr_ready}, 16'd0);
      check({tag, "_done_exec"},  {15'd0, done},        16'd0);
      tick();                           // E0+1: write-back
      check({tag, "_ready_wb"}, {15'd0, instr_ready}, 16'd0);
      check({tag, "_done_wb"},  {15'd0, done},        16'd1);
      tick();                           // E0+2: back to idle
      check({tag, "_ready_idle"}, {15'd0, instr_ready}, 16'd1);
      check({tag, "_done_idle"},  {15'd0, done},        16'd0);
   endtask

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = 8'd0;
      ld_en       = 1'b0;
      ld_addr     = 2'd0;
      ld_data     = '0;
      alu_o       = '0;
      alu_cout    = 1'b0;
      dbg_addr    = 2'd0;

      // ---- Reset then idle ----
      tick();
      check("rst_op",     {14'd0, alu_op},      16'd0);
      check("rst_i0",     alu_i0,               16'd0);
      check("rst_i1",     alu_i1,               16'd0);
      check("rst_result", result,               16'd0);
      check("rst_carry",  {15'd0, carry},       16'd0);
      check("rst_done",   {15'd0, done},        16'd0);
      check("rst_ready",  {15'd0, instr_ready}, 16'd0);
      reset = 1'b0;
      #1;
      check("rel_ready", {15'd0, instr_ready}, 16'd1);
      for (int i = 0; i < 4; i++) check_reg("rel_reg", 2'(i), 16'h0000);

      // ---- Loads, then 00_10_00_01 : R2 = f(R0, R1) ----
      tick();
      ld_en = 1'b1; ld_addr = 2'd0; ld_data = 16'haa55;
      tick();
      ld_addr = 2'd1; ld_data = 16'h55aa;
      tick();
      ld_addr = 2'd3; ld_data = 16'h7777;
      tick();
      ld_en = 1'b0;
      check_reg("ld_r0", 2'd0, 16'haa55);
      check_reg("ld_r1", 2'd1, 16'h55aa);
      check_reg("ld_r3", 2'd3, 16'h7777);
      issue("i1", 8'b00_10_00_01, 16'hffff, 1'b0);
      check("i1_op",     {14'd0, alu_op}, 16'd0);
      check("i1_i0",     alu_i0,          16'haa55);
      check("i1_i1",     alu_i1,          16'h55aa);
      check("i1_result", result,          16'hffff);
      check_reg("i1_r2", 2'd2, 16'hffff);

      // ---- Carry capture: op 01, rd 3, rs1 0, rs2 1 ----
      issue("cy", 8'b01_11_00_01, 16'h0000, 1'b1);
      check("cy_op",    {14'd0, alu_op}, 16'd1);
      check("cy_carry", {15'd0, carry},  16'd1);
      check("cy_res",   result,          16'h0000);
      check_reg("cy_r3", 2'd3, 16'h0000);
      // Next instruction returns cout=0: op 10, rd 3, rs1 1, rs2 2.
      issue("cc", 8'b10_11_01_10, 16'h00ff, 1'b0);
      check("cc_op",    {14'd0, alu_op}, 16'd2);
      check("cc_i0",    alu_i0,          16'h55aa);
      check("cc_i1",    alu_i1,          16'hffff);
      check("cc_carry", {15'd0, carry},  16'd0);
      check_reg("cc_r3", 2'd3, 16'h00ff);

      // ---- Dependency chain: A writes R1, B reads R1 at the first ready ----
      issue("depa", 8'b11_01_00_00, 16'h0001, 1'b0);
      check_reg("depa_r1", 2'd1, 16'h0001);
      issue("depb", 8'b00_00_01_10, 16'h0002, 1'b0);
      check("depb_i0", alu_i0, 16'h0001);
      check("depb_i1", alu_i1, 16'hffff);
      check_reg("depb_r0", 2'd0, 16'h0002);

      // ---- Conflict: load R2=1234 on the write-back edge of R2=5678 ----
      instr_valid = 1'b1;
      instr       = 8'b00_10_00_00;
      tick();
      instr_valid = 1'b0;
      alu_o       = 16'h5678;
      alu_cout    = 1'b0;
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 16'h1234;
      tick();
      ld_en = 1'b0;
      check("wbw_done", {15'd0, done}, 16'd1);
      check_reg("wbw_r2", 2'd2, 16'h5678);
      tick();

      // ---- Conflict: load R0=0f0f on the accept edge reading R0 ----
      ld_en = 1'b1; ld_addr = 2'd0; ld_data = 16'h0f0f;
      issue("lda", 8'b01_01_00_11, 16'habcd, 1'b1);
      check("lda_i0", alu_i0, 16'h0002);
      check("lda_i1", alu_i1, 16'h00ff);
      check_reg("lda_r0", 2'd0, 16'h0f0f);
      check_reg("lda_r1", 2'd1, 16'habcd);

      // ---- Mid-operation reset during EXEC ----
      instr_valid = 1'b1;
      instr       = 8'b00_00_01_01;
      tick();
      instr_valid = 1'b0;
      alu_o       = 16'hffff;
      alu_cout    = 1'b1;
      reset       = 1'b1;
      #1;
      check("mr_done_a",  {15'd0, done},        16'd0);
      check("mr_ready_a", {15'd0, instr_ready}, 16'd0);
      check("mr_i0",      alu_i0,               16'd0);
      tick();
      reset = 1'b0;
      #1;
      check("mr_done_b",  {15'd0, done},        16'd0);
      check("mr_ready_b", {15'd0, instr_ready}, 16'd1);
      check("mr_result",  result,               16'd0);
      check("mr_carry",   {15'd0, carry},       16'd0);
      tick();
      check("mr_done_c", {15'd0, done}, 16'd0);
      for (int i = 0; i < 4; i++) check_reg("mr_reg", 2'(i), 16'h0000);
      tick();
      check("mr_done_d", {15'd0, done}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_issue_regfile.md
# alu_issue_regfile

Operand-supply and write-back stage for the 16-bit `alu`. It holds four 16-bit general registers and accepts one instruction at a time over a valid/ready handshake. For each instruction it drives the ALU's `op`, `i0` and `i1` from registers, captures the ALU's `o` and `cout` one cycle later, and writes the result back to the destination register. A side load port initialises registers, and a combinational debug read port observes them.

## Interface
- `WIDTH`, 16: datapath width; must equal the ALU width.
- `NREG`, 4: number of registers; fixed at 4, so register indices are 2 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction present on `instr`.
- `instr`  in  8  {op[7:6], rd[5:4], rs1[3:2], rs2[1:0]}.
- `instr_ready`  out  1  block can accept an instruction this cycle.
- `ld_en`  in  1  load `ld_data` into register `ld_addr`.
- `ld_addr`  in  2  load target register.
- `ld_data`  in  WIDTH  load value.
- `alu_op`  out  2  to ALU `op`; registered.
- `alu_i0`  out  WIDTH  to ALU `i0`; equals R[rs1]; registered.
- `alu_i1`  out  WIDTH  to ALU `i1`; equals R[rs2]; registered.
- `alu_o`  in  WIDTH  from ALU `o`.
- `alu_cout`  in  1  from ALU `cout`.
- `result`  out  WIDTH  last value written back.
- `carry`  out  1  last `alu_cout` captured.
- `done`  out  1  one-cycle pulse per completed instruction.
- `dbg_addr`  in  2  debug read index.
- `dbg_data`  out  WIDTH  R[dbg_addr]; combinational.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE -> EXEC when `instr_valid & instr_ready`.
  - EXEC -> WB unconditionally.
  - WB -> IDLE unconditionally.
- `instr_ready` = (state == IDLE) & ~reset.
- Accept edge, IDLE -> EXEC:
  - latch rd;
  - `alu_op` <= instr[7:6], `alu_i0` <= R[rs1], `alu_i1` <= R[rs2];
  - reads return pre-edge register contents.
- EXEC -> WB edge:
  - R[rd] <= `alu_o`, `result` <= `alu_o`, `carry` <= `alu_cout`;
  - `done` <= 1.
- WB -> IDLE edge: `done` <= 0.
- `alu_op`, `alu_i0` and `alu_i1` hold their values until the next accept.
- The ALU is purely combinational; the block gives it exactly one cycle (the EXEC state).
- Load port:
  - `ld_en` writes R[ld_addr] <= `ld_data` at the edge, in any state.
  - When `ld_en` and write-back hit the same register at the same edge, write-back wins.
  - When a load and an accept share an edge, operands read the old value.
- Same-register operands (rs1 == rs2, or rd == rs1/rs2) are legal; the destination is overwritten only at write-back.
- `instr` is ignored when `instr_ready` is 0; the upstream holds `instr_valid` until accepted.
- Reset, asserted at any time including mid-instruction:
  - state -> IDLE and all R -> 0;
  - `alu_op`/`alu_i0`/`alu_i1`/`result` -> 0, `carry`/`done` -> 0;
  - the in-flight instruction is discarded with no write-back.

## Timing
- Accept at edge E0. The ALU inputs are valid from E0 until the next accept.
- Write-back and `done` rise at E0+1. `done` is high for exactly the cycle between E0+1 and E0+2.
- `instr_ready` returns high at E0+2, so the next accept is no earlier than E0+3. Throughput is one instruction per 3 cycles.
- Dependent back-to-back instructions need no stall, because write-back always precedes the next operand read.
- `dbg_data` reflects a write in the cycle after the writing edge.

## Test plan
- Reset then idle:
  - all outputs 0 while `reset`=1, and `instr_ready`=0;
  - after release, `instr_ready`=1 and `dbg_data`=0 for all four registers.
- Load, then issue instruction 8'b00_10_00_01, with the bench returning `alu_o`=16'hffff, `alu_cout`=0 during EXEC:
  - loads are R0=16'haa55, R1=16'h55aa;
  - ALU side: `alu_op`=00, `alu_i0`=aa55, `alu_i1`=55aa one cycle after accept;
  - write-back: R2=ffff, `result`=ffff;
  - handshake: `done` pulses once, and `instr_ready` is low for exactly 2 cycles.
- Carry capture: the bench returns `alu_o`=16'h0000, `alu_cout`=1 for op 01, rd=3 -> R3=0000, `carry`=1. The next instruction, returning cout=0, clears `carry`.
- Dependency chain: instr A writes R1=16'h0001, and B (rs1=1) issues at the first ready -> B's `alu_i0`=0001.
- Conflicts:
  - `ld_en` to R2 with data 1234 at the same edge as write-back to R2 of 5678 -> R2=5678;
  - a load to R0 of 0f0f on an accept edge reading R0 -> `alu_i0` shows the old R0.
- Mid-operation reset: assert `reset` during EXEC -> no write-back, `done` never pulses, all registers 0, `instr_ready`=1 after release.
